// File: rtl/crc_stream_if.sv
// crc_stream_if: beat input and result output bundle for crc_stream
interface crc_stream_if #(
    parameter int LANES = 4,
    parameter int CRC_W = 32
);
    logic               rx_we;
    logic               rx_ready;
    logic               rx_sof;
    logic               rx_eof;
    logic [LANES-1:0]   rx_keep;
    logic [8*LANES-1:0] rx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [CRC_W-1:0]   tx_crc;
    logic               tx_match;
    logic               err;
    modport master (
        output rx_we, rx_sof, rx_eof, rx_keep, rx_data, tx_ready,
        input  rx_ready, tx_valid, tx_crc, tx_match, err
    );
    modport slave (
        input  rx_we, rx_sof, rx_eof, rx_keep, rx_data, tx_ready,
        output rx_ready, tx_valid, tx_crc, tx_match, err
    );
endinterface

// File: rtl/crc_stream.sv
// crc_stream: multi-lane streaming CRC with framing FSM and valid/ready result port
// Optional feature macro CRC_CHECK_EN: residue comparison driving tx_match
module crc_stream #(
    parameter int          LANES   = 4,
    parameter int          CRC_W   = 32,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
    parameter bit          REFIN   = 1'b1,
    parameter bit          REFOUT  = 1'b1,
    parameter logic [31:0] RESIDUE = 32'hDEBB20E3
) (
    input logic         clk,
    input logic         reset,
    crc_stream_if.slave bus
);
    localparam int CW = $clog2(LANES + 1);
    localparam logic [CRC_W-1:0] P  = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] IV = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XO = XOROUT[CRC_W-1:0];

    typedef enum logic {IDLE, FRAME} state_t;

    state_t             state_q, state_d;
    logic               rx_ready, accept, beat_ok, run, fb, load;
    logic [CW-1:0]      cnt;
    logic               s1_v_q, s1_v_d, s1_init_q, s1_init_d, s1_eof_q, s1_eof_d;
    logic [CW-1:0]      s1_cnt_q, s1_cnt_d;
    logic [8*LANES-1:0] s1_data_q, s1_data_d;
    logic [CRC_W-1:0]   crc_q, crc_d, c, refl, tx_crc_q, tx_crc_d;
    logic               s2_eof_q, s2_eof_d, tx_valid_q, tx_valid_d, err_q, err_d;

    assign rx_ready = ~(tx_valid_q & ~bus.tx_ready);
    assign accept   = bus.rx_we & rx_ready;

    // Framing FSM, eof byte count and stage-1 capture of the accepted beat
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        beat_ok = 1'b0;
        cnt     = '0;
        run     = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            run = run & bus.rx_keep[i];
            cnt = cnt + CW'(run);
        end
        if (!bus.rx_eof) cnt = CW'(LANES);
        if (accept) begin
            beat_ok = bus.rx_sof | (state_q == FRAME);
            err_d   = (state_q == FRAME) ? bus.rx_sof : ~bus.rx_sof;
            if (beat_ok) state_d = bus.rx_eof ? IDLE : FRAME;
        end
        s1_v_d    = rx_ready ? beat_ok : s1_v_q;
        s1_init_d = rx_ready ? bus.rx_sof : s1_init_q;
        s1_eof_d  = rx_ready ? bus.rx_eof : s1_eof_q;
        s1_cnt_d  = rx_ready ? cnt : s1_cnt_q;
        s1_data_d = rx_ready ? bus.rx_data : s1_data_q;
    end

    // Stage 2: unrolled bit-serial update over the valid bytes, lane 0 first
    always_comb begin
        c  = s1_init_q ? IV : crc_q;
        fb = 1'b0;
        for (int i = 0; i < LANES; i++)
            for (int j = 0; j < 8; j++)
                if (i < int'(s1_cnt_q)) begin
                    fb = c[CRC_W-1] ^ s1_data_q[8*i + (REFIN ? j : 7 - j)];
                    c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? P : '0);
                end
        crc_d    = (s1_v_q & rx_ready) ? c : crc_q;
        s2_eof_d = rx_ready ? (s1_v_q & s1_eof_q) : s2_eof_q;
    end

    // Result register: loads when a finished frame leaves stage 2, holds until taken
    always_comb begin
        for (int i = 0; i < CRC_W; i++) refl[i] = REFOUT ? crc_q[CRC_W-1-i] : crc_q[i];
        load       = s2_eof_q & rx_ready;
        tx_valid_d = load | (tx_valid_q & ~bus.tx_ready);
        tx_crc_d   = load ? refl ^ XO : tx_crc_q;
    end

    // State and pipeline registers; reset drops any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            s1_v_q     <= 1'b0;
            s1_init_q  <= 1'b0;
            s1_eof_q   <= 1'b0;
            s1_cnt_q   <= '0;
            s1_data_q  <= '0;
            crc_q      <= '0;
            s2_eof_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_crc_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_v_q     <= s1_v_d;
            s1_init_q  <= s1_init_d;
            s1_eof_q   <= s1_eof_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_data_q  <= s1_data_d;
            crc_q      <= crc_d;
            s2_eof_q   <= s2_eof_d;
            tx_valid_q <= tx_valid_d;
            tx_crc_q   <= tx_crc_d;
            err_q      <= err_d;
        end
    end

    assign bus.rx_ready = rx_ready;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_crc   = tx_crc_q;
    assign bus.err      = err_q;

`ifdef CRC_CHECK_EN
    localparam logic [CRC_W-1:0] RES = RESIDUE[CRC_W-1:0];
    logic tx_match_q, tx_match_d;

    // Residue compare on the output-reflected register before XOROUT, held with tx_crc
    always_comb tx_match_d = load ? (refl == RES) : tx_match_q;

    // Match flag register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tx_match_q <= 1'b0;
        else       tx_match_q <= tx_match_d;
    end

    assign bus.tx_match = tx_match_q;
`else
    assign bus.tx_match = 1'b0;
`endif
endmodule

// File: tb/tb_crc_stream.sv
// tb_crc_stream: directed and randomized checks of crc_stream against a reflected CRC-32 model
`timescale 1ns/1ps
module tb_crc_stream;
    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;
    int          err_cnt = 0;
    logic [32:0] got[$];
    logic [32:0] got1[$];

    crc_stream_if #(.LANES(4), .CRC_W(32)) b();
    crc_stream_if #(.LANES(1), .CRC_W(32)) b1();

    crc_stream #(.LANES(4)) dut  (.clk(clk), .reset(reset), .bus(b));
    crc_stream #(.LANES(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;

    // Capture every result handshake (committed at the following rising edge) and err pulses
    always @(negedge clk) begin
        if (b.tx_valid && b.tx_ready) got.push_back({b.tx_match, b.tx_crc});
        if (b1.tx_valid && b1.tx_ready) got1.push_back({b1.tx_match, b1.tx_crc});
        if (b.err) err_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Reflected (right-shifting) CRC-32; returns {expected match, expected crc}
    function automatic logic [32:0] model(input bytes_t q);
        logic [31:0] r;
        logic        m;
        r = 32'hFFFFFFFF;
        foreach (q[i]) begin
            r = r ^ {24'h0, q[i]};
            repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
`ifdef CRC_CHECK_EN
        m = (r == 32'hDEBB20E3);
`else
        m = 1'b0;
`endif
        return {m, ~r};
    endfunction

    function automatic bytes_t nine();
        bytes_t q;
        for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
        return q;
    endfunction

    task automatic send_beat(input logic sof, input logic eof, input logic [3:0] keep, input logic [31:0] data);
        logic ok;
        ok = 1'b0;
        b.rx_we = 1'b1; b.rx_sof = sof; b.rx_eof = eof; b.rx_keep = keep; b.rx_data = data;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = b.rx_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_beat rx_ready got %b want 1", b.rx_ready);
        end
        b.rx_we = 1'b0; b.rx_sof = 1'b0; b.rx_eof = 1'b0;
    endtask

    task automatic send_frame(input bytes_t q, input bit rnd);
        int          nb, nv;
        logic [31:0] d;
        logic [3:0]  kp;
        nb = (q.size() + 3) / 4;
        if (nb == 0) nb = 1;
        for (int k = 0; k < nb; k++) begin
            d  = rnd ? $urandom : 32'h0;
            nv = q.size() - 4 * k;
            if (nv > 4) nv = 4;
            for (int i = 0; i < nv; i++) d[8*i +: 8] = q[4*k + i];
            kp = 4'((1 << nv) - 1);
            if (rnd && nv < 4) kp = kp | (4'($urandom) & ~4'((2 << nv) - 1));
            if (rnd && k != nb - 1) kp = 4'($urandom);
            if (rnd && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send_beat(k == 0, k == nb - 1, kp, d);
        end
    endtask

    task automatic wait_results(input int n);
        for (int t = 0; t < 200 && got.size() < n; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({b.rx_ready, b.tx_valid, b.tx_match, b.err, b.tx_crc} !== {4'b1000, 32'h0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b v=%b m=%b e=%b crc=%h want 1 0 0 0 0", b.rx_ready, b.tx_valid, b.tx_match, b.err, b.tx_crc);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_check_vector();
        logic        v0, v1;
        logic [32:0] e;
        e = model(nine());
        got.delete();
        send_frame(nine(), 1'b0);
        @(negedge clk); v0 = b.tx_valid;
        @(negedge clk); v1 = b.tx_valid;
        @(negedge clk);
        checks++;
        if ({v0, v1, b.tx_valid} !== 3'b001) begin
            errors++; $display("FAIL latency got %b%b%b want 001", v0, v1, b.tx_valid);
        end
        checks++;
        if (b.tx_crc !== 32'hCBF43926) begin
            errors++; $display("FAIL check_crc got %h want cbf43926", b.tx_crc);
        end
        @(negedge clk);
        checks++;
        if (b.tx_valid !== 1'b0) begin
            errors++; $display("FAIL single_pulse tx_valid got %b want 0", b.tx_valid);
        end
        wait_results(1);
        checks++;
        if (got.size() != 1 || got[0] !== e) begin
            errors++; $display("FAIL check_model n=%0d got %h want %h", got.size(), got.size() ? got[0] : 33'h0, e);
        end
    endtask

    task automatic test_fcs();
        bytes_t      q;
        logic [32:0] e;
        logic        want_m;
`ifdef CRC_CHECK_EN
        want_m = 1'b1;
`else
        want_m = 1'b0;
`endif
        q = nine();
        q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
        e = model(q);
        got.delete();
        send_frame(q, 1'b0);
        wait_results(1);
        checks++;
        if (got.size() != 1 || got[0] !== e || got[0][32] !== want_m) begin
            errors++; $display("FAIL fcs_good n=%0d got %h want %h match %b", got.size(), got.size() ? got[0] : 33'h0, e, want_m);
        end
        q[3] = q[3] ^ 8'(1 << $urandom_range(0, 7));
        e = model(q);
        got.delete();
        send_frame(q, 1'b0);
        wait_results(1);
        checks++;
        if (got.size() != 1 || got[0] !== e || got[0][32] !== 1'b0) begin
            errors++; $display("FAIL fcs_bad n=%0d got %h want %h match 0", got.size(), got.size() ? got[0] : 33'h0, e);
        end
    endtask

    task automatic test_empty();
        got.delete();
        send_beat(1'b1, 1'b1, 4'h0, $urandom);
        wait_results(1);
        checks++;
        if (got.size() != 1 || got[0] !== 33'h0) begin
            errors++; $display("FAIL empty_frame n=%0d got %h want 0", got.size(), got.size() ? got[0] : 33'h0);
        end
    endtask

    task automatic test_idle_err();
        int e0;
        e0 = err_cnt;
        got.delete();
        send_beat(1'b0, 1'b0, 4'hF, $urandom);
        send_beat(1'b0, 1'b1, 4'h3, $urandom);
        wait_results(1);
        checks++;
        if (err_cnt - e0 != 2 || got.size() != 0) begin
            errors++; $display("FAIL idle_err pulses got %0d results %0d want 2 and 0", err_cnt - e0, got.size());
        end
    endtask

    task automatic test_sof_restart();
        int e0;
        e0 = err_cnt;
        got.delete();
        send_beat(1'b1, 1'b0, 4'hF, $urandom);
        send_beat(1'b0, 1'b0, 4'hF, $urandom);
        send_frame(nine(), 1'b0);
        wait_results(1);
        checks++;
        if (err_cnt - e0 != 1) begin
            errors++; $display("FAIL restart_err got %0d pulses want 1", err_cnt - e0);
        end
        checks++;
        if (got.size() != 1 || got[0][31:0] !== 32'hCBF43926) begin
            errors++; $display("FAIL restart_result n=%0d got %h want cbf43926", got.size(), got.size() ? got[0][31:0] : 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        bytes_t      f1, f2;
        logic [31:0] c0;
        logic        found;
        for (int i = 0; i < 8; i++) f1.push_back(8'($urandom));
        for (int i = 0; i < 28; i++) f2.push_back(8'($urandom));
        got.delete();
        b.tx_ready = 1'b0;
        fork
            begin
                send_frame(f1, 1'b0);
                send_frame(f2, 1'b0);
            end
            begin
                found = 1'b0;
                for (int t = 0; t < 100 && !found; t++) begin
                    @(negedge clk);
                    found = b.tx_valid;
                end
                c0 = b.tx_crc;
                checks++;
                if (!found) begin
                    errors++; $display("FAIL b2b_first_valid got 0 want 1");
                end
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checks++;
                    if ({b.rx_ready, b.tx_valid} !== 2'b01 || b.tx_crc !== c0) begin
                        errors++; $display("FAIL b2b_stall rdy=%b v=%b crc=%h want 0 1 %h", b.rx_ready, b.tx_valid, b.tx_crc, c0);
                    end
                end
                @(posedge clk);
                #1 b.tx_ready = 1'b1;
            end
        join
        wait_results(2);
        checks++;
        if (got.size() != 2 || got[0] !== model(f1) || got[1] !== model(f2)) begin
            errors++; $display("FAIL b2b_order n=%0d got %h %h want %h %h", got.size(), got.size() > 0 ? got[0] : 33'h0, got.size() > 1 ? got[1] : 33'h0, model(f1), model(f2));
        end
    endtask

    task automatic test_reset_midframe();
        got.delete();
        send_beat(1'b1, 1'b0, 4'hF, $urandom);
        send_beat(1'b0, 1'b0, 4'hF, $urandom);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({b.rx_ready, b.tx_valid, b.tx_match, b.err, b.tx_crc} !== {4'b1000, 32'h0}) begin
            errors++;
            $display("FAIL midreset_state got rdy=%b v=%b m=%b e=%b crc=%h want 1 0 0 0 0", b.rx_ready, b.tx_valid, b.tx_match, b.err, b.tx_crc);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        send_frame(nine(), 1'b0);
        wait_results(1);
        checks++;
        if (got.size() != 1 || got[0][31:0] !== 32'hCBF43926) begin
            errors++; $display("FAIL midreset_result n=%0d got %h want cbf43926", got.size(), got.size() ? got[0][31:0] : 32'h0);
        end
    endtask

    task automatic test_random();
        logic [32:0] exp_q[$];
        bytes_t      q;
        bit          done;
        done = 1'b0;
        got.delete();
        fork
            begin
                for (int f = 0; f < 10; f++) begin
                    q.delete();
                    for (int i = 0; i < int'($urandom_range(0, 25)); i++) q.push_back(8'($urandom));
                    exp_q.push_back(model(q));
                    send_frame(q, 1'b1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 b.tx_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        b.tx_ready = 1'b1;
        wait_results(10);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL random_frame%0d got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_lanes1();
        bytes_t q;
        logic   ok;
        q = nine();
        got1.delete();
        for (int i = 0; i < 9; i++) begin
            b1.rx_we = 1'b1; b1.rx_sof = (i == 0); b1.rx_eof = (i == 8); b1.rx_keep = 1'b1; b1.rx_data = q[i];
            ok = 1'b0;
            for (int t = 0; t < 100 && !ok; t++) begin
                @(negedge clk);
                ok = b1.rx_ready;
                @(posedge clk);
                #1;
            end
        end
        b1.rx_we = 1'b0; b1.rx_sof = 1'b0; b1.rx_eof = 1'b0;
        for (int t = 0; t < 50 && got1.size() < 1; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (got1.size() != 1 || got1[0] !== model(q) || got1[0][31:0] !== 32'hCBF43926) begin
            errors++; $display("FAIL lanes1 n=%0d got %h want %h", got1.size(), got1.size() ? got1[0] : 33'h0, model(q));
        end
    endtask

    initial begin
        b.rx_we = 1'b0; b.rx_sof = 1'b0; b.rx_eof = 1'b0; b.rx_keep = '0; b.rx_data = '0; b.tx_ready = 1'b1;
        b1.rx_we = 1'b0; b1.rx_sof = 1'b0; b1.rx_eof = 1'b0; b1.rx_keep = '0; b1.rx_data = '0; b1.tx_ready = 1'b1;
        test_reset();
        test_check_vector();
        test_fcs();
        test_empty();
        test_idle_err();
        test_sof_restart();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        test_lanes1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/crc_stream.md
Name: crc_stream

Overview:
- Parametrised streaming CRC engine. Successor to the byte-serial CRC32 core.
- Accepts LANES bytes per beat with explicit frame delimiters and a partial last beat.
- Produces one final CRC per frame through a valid/ready result port with backpressure.
- Sits between the packet datapath (serial/Ethernet framing) and the frame checker/appender.

Parameters:
- LANES, 4, bytes per input beat (1..8); lane 0 = rx_data[7:0] = first byte on the wire.
- CRC_W, 32, CRC width (8..32).
- POLY, 32'h04C11DB7, generator polynomial, normal form, low CRC_W bits used.
- INIT, 32'hFFFFFFFF, register value at frame start.
- XOROUT, 32'hFFFFFFFF, XOR applied to the final register.
- REFIN, 1, 1 = each byte is processed LSB-first.
- REFOUT, 1, 1 = register is bit-reversed before XOROUT.
- RESIDUE, 32'hDEBB20E3, expected pre-XOROUT register after data plus FCS (CRC_CHECK_EN only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_we  in  1  input beat valid.
- rx_ready  out  1  beat accepted when rx_we & rx_ready.
- rx_sof  in  1  beat is the first of a frame.
- rx_eof  in  1  beat is the last of a frame.
- rx_keep  in  LANES  byte enables; honoured on eof beats only.
- rx_data  in  8*LANES  data bytes.
- tx_valid  out  1  final CRC available.
- tx_ready  in  1  consumer accepts the result.
- tx_crc  out  CRC_W  final CRC.
- tx_match  out  1  residue check result, qualified by tx_valid.
- err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset values: rx_ready=1, tx_valid=0, tx_crc=0, tx_match=0, err=0, state=IDLE, pipeline empty. Reset mid-frame discards the frame; no result is ever emitted for it.
- Pipeline: stage 1 registers the accepted beat and byte count; stage 2 updates the CRC register; the output register loads on the eof beat.
- Latency: tx_valid rises 2 cycles after the eof beat is accepted.
- Throughput: one beat per cycle when tx_ready is held high.
- Byte count on eof beats: the number of contiguous ones in rx_keep starting at lane 0; bits above the first zero are ignored. Non-eof beats always process all LANES bytes.
- Byte update: bytes are processed lane 0 first; per-byte CRC is an unrolled combinational loop.
- FSM states:
  - IDLE: sof beat → FRAME, register=INIT, then the beat is processed. sof+eof on the same beat → single-beat frame, result emitted, stays IDLE. Non-sof beat → dropped, err pulse.
  - FRAME: plain beat → processed. eof beat → processed, result emitted, → IDLE. sof beat → err pulse, old frame discarded without a result, register=INIT, new frame starts with this beat.
- Result: tx_crc = (REFOUT ? reverse(reg) : reg) ^ XOROUT.
- Empty frame (sof+eof with keep=0): result is INIT^XOROUT after reflection.
- Result handshake: tx_valid and tx_crc are held stable until tx_valid & tx_ready, then tx_valid drops the next cycle. tx_crc holds its last value afterwards.
- Backpressure: rx_ready = ~(tx_valid & ~tx_ready). While rx_ready is low, both pipeline stages freeze. An accept and a new result in the same cycle are legal: the new result loads and tx_valid stays high.
- rx_we while rx_ready is low: the beat is not accepted; the source must hold it.
- Width rules: POLY, INIT, XOROUT and RESIDUE are truncated to CRC_W bits.

Optional Feature:
- Macro: CRC_CHECK_EN.
- Defined:
  - tx_match = 1 when the final pre-XOROUT register equals RESIDUE; it is loaded and held together with tx_crc.
  - Used for frames that carry their FCS (FCS bytes LSB-first).
- Undefined:
  - tx_match tied to 0; no comparator is synthesised.

Test Plan:
- Defaults, ASCII "123456789" as 3 beats (keep on the last beat = 4'b0001), tx_ready=1 → tx_valid 2 cycles after eof, tx_crc=32'hCBF43926, single pulse.
- Same frame followed by FCS bytes 26 39 F4 CB (last beat carries 9,26,39,F4 plus one beat CB, keep=0001), CRC_CHECK_EN defined → tx_match=1. Corrupt one data bit → tx_match=0. Macro undefined → tx_match=0 always.
- sof+eof, keep=0 → tx_crc=32'h00000000. Non-sof beat while IDLE → err pulse, no tx_valid.
- Frame A mid-way, then sof of "123456789" → err pulse, exactly one result, 32'hCBF43926.
- Two back-to-back frames with tx_ready low for 5 cycles after the first result → rx_ready low those cycles, tx_crc stable, both CRCs delivered in order, no beat lost.
- Assert reset mid-frame, release, send "123456789" → outputs at reset values during reset, only 32'hCBF43926 emitted afterwards. Repeat with LANES=1: same CRC, 9 beats.
